// File: rtl/pq_pkg.sv
// pq_pkg: types and helpers shared by the priority-queue blocks.
//   kv_t      : packed key/value entry
//   pq_type_t : queue ordering (MIN_PQ / MAX_PQ)
//   PQ_TYPE   : ordering used by this build
//   better()  : strict "x ranks ahead of y" under PQ_TYPE
package pq_pkg;

  localparam int KEY_WIDTH = 8;
  localparam int VAL_WIDTH = 8;

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] value;
  } kv_t;

  typedef enum logic {MIN_PQ, MAX_PQ} pq_type_t;

  localparam pq_type_t PQ_TYPE = MIN_PQ;

  // Strict compare: equal keys are never "better", so a new entry lands
  // behind existing equal keys (FIFO among ties).
  function automatic logic better(kv_t x, kv_t y);
    if (PQ_TYPE == MIN_PQ) return x.key < y.key;
    else                   return x.key > y.key;
  endfunction

endpackage

// File: rtl/ra_pq_shift_cell.sv
// ra_pq_shift_cell: one slot of the register-array priority queue.
//   clk, rst              : clock, synchronous active-high reset
//   beat                  : kvi beats this slot (or slot empty)
//   beat_prev, beat_next  : beat of the slot above / below (below of last = 1)
//   slot_prev, vld_prev   : neighbour above (toward head)
//   slot_next, vld_next   : neighbour below (toward tail)
//   kvi                   : entry being inserted
//   enq_ok, deq_ok        : qualified enqueue / dequeue
//   slot, vld             : this slot's registered contents
module ra_pq_shift_cell
  import pq_pkg::*;
#(
  parameter bit FIRST = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic beat,
  input  logic beat_prev,
  input  logic beat_next,
  input  kv_t  slot_prev,
  input  logic vld_prev,
  input  kv_t  slot_next,
  input  logic vld_next,
  input  kv_t  kvi,
  input  logic enq_ok,
  input  logic deq_ok,
  output kv_t  slot,
  output logic vld
);

  kv_t  slot_d;
  logic vld_d;

  // beat is a thermometer over the slots (contents are sorted and valid
  // entries are contiguous), so the insert point is where beat first rises.
  always_comb begin
    slot_d = slot;
    vld_d  = vld;
    unique case ({enq_ok, deq_ok})
      2'b10: begin
        if (beat && !beat_prev) begin
          slot_d = kvi;
          vld_d  = 1'b1;
        end else if (beat) begin
          slot_d = slot_prev;
          vld_d  = vld_prev;
        end
      end
      2'b01: begin
        slot_d = slot_next;
        vld_d  = vld_next;
      end
      2'b11: begin
        // Replace: head leaves, everything ahead of the insert point moves
        // up one; the insert point is one slot earlier than for a plain enq
        // (clamped to slot 0).
        if (!beat_next) begin
          slot_d = slot_next;
          vld_d  = vld_next;
        end else if (FIRST || !beat) begin
          slot_d = kvi;
          vld_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
      vld  <= 1'b0;
    end else begin
      slot <= slot_d;
      vld  <= vld_d;
    end
  end

endmodule

// File: rtl/ra_pq_shift.sv
// ra_pq_shift: sorted register-array priority queue, single-cycle
// enqueue / dequeue / replace. Slot 0 is always the head.
//   clk, rst : clock, synchronous active-high reset
//   enq, kvi : enqueue request and entry
//   deq      : dequeue request (removes head)
//   kvo      : head entry (slot 0)
//   empty    : no valid entries
//   full     : DEPTH valid entries
//   count    : number of valid entries
module ra_pq_shift
  import pq_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq,
  input  kv_t           kvi,
  input  logic          deq,
  output kv_t           kvo,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  kv_t  [DEPTH-1:0] slot, slot_prev, slot_next;
  logic [DEPTH-1:0] vld, vld_prev, vld_next, beat_prev;
  logic [DEPTH:0]   beat;
  logic             enq_ok, deq_ok;

  assign empty  = (count == '0);
  assign full   = (count == FULL);
  assign enq_ok = enq & (~full | deq);
  assign deq_ok = deq & ~empty;
  assign kvo    = slot[0];

  // Past the tail counts as beaten so a replace can land in the last slot.
  assign beat[DEPTH] = 1'b1;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    assign beat[i] = ~vld[i] | better(kvi, slot[i]);

    if (i == 0) begin : g_head
      assign slot_prev[i] = '0;
      assign vld_prev[i]  = 1'b0;
      assign beat_prev[i] = 1'b0;
    end else begin : g_mid
      assign slot_prev[i] = slot[i-1];
      assign vld_prev[i]  = vld[i-1];
      assign beat_prev[i] = beat[i-1];
    end

    if (i == DEPTH-1) begin : g_tail
      assign slot_next[i] = '0;
      assign vld_next[i]  = 1'b0;
    end else begin : g_body
      assign slot_next[i] = slot[i+1];
      assign vld_next[i]  = vld[i+1];
    end

    ra_pq_shift_cell #(.FIRST(i == 0)) u_cell (
      .clk       (clk),
      .rst       (rst),
      .beat      (beat[i]),
      .beat_prev (beat_prev[i]),
      .beat_next (beat[i+1]),
      .slot_prev (slot_prev[i]),
      .vld_prev  (vld_prev[i]),
      .slot_next (slot_next[i]),
      .vld_next  (vld_next[i]),
      .kvi       (kvi),
      .enq_ok    (enq_ok),
      .deq_ok    (deq_ok),
      .slot      (slot[i]),
      .vld       (vld[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)                    count <= '0;
    else if (enq_ok && !deq_ok) count <= count + ONE;
    else if (deq_ok && !enq_ok) count <= count - ONE;
  end

endmodule
